// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file write port between core writeback and a buffered late-write path,
// with starvation stall and an outstanding-load scoreboard for hazard detection.
module regfile_wb_arbiter #(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        wb_valid_i,
    input  logic [4:0]  wb_addr_i,
    input  logic [31:0] wb_data_i,
    input  logic        ld_valid_i,
    output logic        ld_ready_o,
    input  logic [4:0]  ld_addr_i,
    input  logic [31:0] ld_data_i,
    input  logic        ld_issue_i,
    input  logic [4:0]  ld_issue_addr_i,
    input  logic [4:0]  rs1_chk_i,
    input  logic [4:0]  rs2_chk_i,
    input  logic [4:0]  rd_chk_i,
    output logic        hazard_o,
    output logic        stall_o,
    output logic        rd_wren_o,
    output logic [4:0]  rd_addr_o,
    output logic [31:0] rd_data_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]    r_addr_q [FIFO_DEPTH];
    logic [31:0]   r_data_q [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [SW-1:0] r_starve;
    logic [31:0]   r_pend;
    logic          r_en;

    logic          w_empty, w_stall, w_push, w_pop, w_core_req, w_core;
    logic [4:0]    w_hd_addr;
    logic [31:0]   w_hd_data, w_set, w_clr;

    // r_en holds every output at 0 until the first edge after reset release
    assign w_empty    = r_count == '0;
    assign w_stall    = r_en && r_starve == SW'(STARVE_LIMIT);
    assign ld_ready_o = r_en && r_count < CW'(FIFO_DEPTH);
    assign w_push     = ld_valid_i && ld_ready_o;
    assign w_core_req = wb_valid_i && wb_addr_i != 5'd0;
    assign w_pop      = r_en && !w_empty && (w_stall || !w_core_req);
    assign w_core     = r_en && !w_stall && w_core_req;
    assign w_hd_addr  = r_addr_q[r_rd_ptr];
    assign w_hd_data  = r_data_q[r_rd_ptr];

    assign rd_wren_o = w_pop ? w_hd_addr != 5'd0 : w_core;
    assign rd_addr_o = w_pop ? w_hd_addr : w_core ? wb_addr_i : 5'd0;
    assign rd_data_o = w_pop ? w_hd_data : w_core ? wb_data_i : 32'd0;
    assign stall_o   = w_stall;
    assign hazard_o  = r_en && (r_pend[rs1_chk_i] | r_pend[rs2_chk_i] | r_pend[rd_chk_i]);

    assign w_set = (ld_issue_i && ld_issue_addr_i != 5'd0) ? 32'd1 << ld_issue_addr_i : 32'd0;
    assign w_clr = w_pop ? 32'd1 << w_hd_addr : 32'd0;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_addr_q[r_wr_ptr] <= ld_addr_i;
            r_data_q[r_wr_ptr] <= ld_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_en     <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_starve <= '0;
            r_pend   <= '0;
        end else begin
            r_en     <= 1'b1;
            r_wr_ptr <= r_wr_ptr + AW'(w_push);
            r_rd_ptr <= r_rd_ptr + AW'(w_pop);
            r_count  <= r_count + CW'(w_push) - CW'(w_pop);
            r_starve <= (w_pop || w_empty) ? '0 : (r_starve == SW'(STARVE_LIMIT)) ? r_starve : r_starve + 1'b1;
            r_pend   <= ((r_pend & ~w_clr) | w_set) & ~32'd1;
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed vectors and hand sequences for the write-port arbiter.
module tb_regfile_wb_arbiter;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        wb_valid_i, ld_valid_i, ld_issue_i;
    logic [4:0]  wb_addr_i, ld_addr_i, ld_issue_addr_i, rs1_chk_i, rs2_chk_i, rd_chk_i;
    logic [31:0] wb_data_i, ld_data_i;
    logic        ld_ready_o, hazard_o, stall_o, rd_wren_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;

    int checks = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    regfile_wb_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .wb_valid_i(wb_valid_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
        .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o), .ld_addr_i(ld_addr_i), .ld_data_i(ld_data_i),
        .ld_issue_i(ld_issue_i), .ld_issue_addr_i(ld_issue_addr_i),
        .rs1_chk_i(rs1_chk_i), .rs2_chk_i(rs2_chk_i), .rd_chk_i(rd_chk_i),
        .hazard_o(hazard_o), .stall_o(stall_o),
        .rd_wren_o(rd_wren_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o)
    );

    typedef struct {
        logic        wb_valid;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic        exp_wren;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    initial begin
        vec_t vecs [4];
        int   waited;
        vecs[0] = '{1'b1, 5'd1,  32'hAAAA0001, 1'b1, 5'd1,  32'hAAAA0001};
        vecs[1] = '{1'b1, 5'd0,  32'hBBBB0002, 1'b0, 5'd0,  32'h0};
        vecs[2] = '{1'b0, 5'd7,  32'hCCCC0003, 1'b0, 5'd0,  32'h0};
        vecs[3] = '{1'b1, 5'd31, 32'hDDDD0004, 1'b1, 5'd31, 32'hDDDD0004};

        rst_ni = 1'b0;
        wb_valid_i = 1'b1; wb_addr_i = 5'd3; wb_data_i = 32'h1;
        ld_valid_i = 1'b0; ld_addr_i = 5'd0; ld_data_i = 32'h0;
        ld_issue_i = 1'b0; ld_issue_addr_i = 5'd0;
        rs1_chk_i = 5'd0; rs2_chk_i = 5'd0; rd_chk_i = 5'd0;

        // reset gating and first-edge release
        step; step;
        chk("rst_wren", rd_wren_o, 0);
        chk("rst_ready", ld_ready_o, 0);
        chk("rst_addr", rd_addr_o, 0);
        chk("rst_stall", stall_o, 0);
        rst_ni = 1'b1; settle;
        chk("rel_ready_pre_edge", ld_ready_o, 0);
        step;
        chk("rel_ready", ld_ready_o, 1);
        chk("rel_core_wren", rd_wren_o, 1);
        chk("rel_hazard", hazard_o, 0);

        for (int i = 0; i < 4; i++) begin
            step;
            wb_valid_i = vecs[i].wb_valid; wb_addr_i = vecs[i].wb_addr; wb_data_i = vecs[i].wb_data;
            settle;
            chk($sformatf("vec%0d_wren", i), rd_wren_o, vecs[i].exp_wren);
            chk($sformatf("vec%0d_addr", i), rd_addr_o, vecs[i].exp_addr);
            chk($sformatf("vec%0d_data", i), rd_data_o, vecs[i].exp_data);
        end

        // late write x5 in idle: no bypass, presented next cycle
        step;
        wb_valid_i = 1'b0;
        ld_valid_i = 1'b1; ld_addr_i = 5'd5; ld_data_i = 32'hDEADBEEF;
        settle;
        chk("lw5_no_bypass", rd_wren_o, 0);
        step;
        ld_valid_i = 1'b0; settle;
        chk("lw5_wren", rd_wren_o, 1);
        chk("lw5_addr", rd_addr_o, 5);
        chk("lw5_data", rd_data_o, 32'hDEADBEEF);
        step;
        chk("lw5_empty_wren", rd_wren_o, 0);
        chk("lw5_ready", ld_ready_o, 1);

        // starvation: core writes x1 every cycle while x2, x3 queue
        wb_valid_i = 1'b1; wb_addr_i = 5'd1; wb_data_i = 32'h11;
        ld_valid_i = 1'b1; ld_addr_i = 5'd2; ld_data_i = 32'h22;
        settle;
        step;
        ld_addr_i = 5'd3; ld_data_i = 32'h33; settle;
        chk("st_ready_one", ld_ready_o, 1);
        chk("st_core_w1", rd_addr_o, 1);
        chk("st_nostall_w1", stall_o, 0);
        step;
        ld_valid_i = 1'b0; settle;
        chk("st_ready_full", ld_ready_o, 0);
        chk("st_core_w2", rd_data_o, 32'h11);
        waited = 2;
        for (int i = 0; i < 2; i++) begin
            step; waited++;
            chk($sformatf("st_nostall_w%0d", waited), stall_o, 0);
            chk($sformatf("st_core_w%0d", waited), rd_addr_o, 1);
        end
        step;
        chk("st_stall_x2", stall_o, 1);
        chk("st_grant_x2_addr", rd_addr_o, 2);
        chk("st_grant_x2_data", rd_data_o, 32'h22);
        chk("st_grant_x2_wren", rd_wren_o, 1);
        step;
        chk("st_unstall", stall_o, 0);
        chk("st_core_repres", rd_addr_o, 1);
        chk("st_core_repres_data", rd_data_o, 32'h11);
        chk("st_ready_again", ld_ready_o, 1);
        for (int i = 0; i < 3; i++) begin
            step;
            chk($sformatf("st_x3_wait%0d", i + 2), stall_o, 0);
        end
        step;
        chk("st_stall_x3", stall_o, 1);
        chk("st_grant_x3_addr", rd_addr_o, 3);
        step;
        chk("st_after_x3_stall", stall_o, 0);
        chk("st_after_x3_core", rd_addr_o, 1);
        wb_valid_i = 1'b0; settle;
        chk("st_drained", rd_wren_o, 0);

        // scoreboard: x7 pending until its pop
        ld_issue_i = 1'b1; ld_issue_addr_i = 5'd7; rs1_chk_i = 5'd7; settle;
        chk("hz7_not_yet", hazard_o, 0);
        step;
        ld_issue_i = 1'b0; settle;
        chk("hz7_set", hazard_o, 1);
        step;
        ld_valid_i = 1'b1; ld_addr_i = 5'd7; ld_data_i = 32'h77; settle;
        chk("hz7_held", hazard_o, 1);
        step;
        ld_valid_i = 1'b0; settle;
        chk("hz7_pop_addr", rd_addr_o, 7);
        chk("hz7_pop_cycle", hazard_o, 1);
        step;
        chk("hz7_cleared", hazard_o, 0);
        rs1_chk_i = 5'd0;

        // x9: reissue in the pop cycle keeps it pending
        ld_issue_i = 1'b1; ld_issue_addr_i = 5'd9; rd_chk_i = 5'd9;
        step;
        ld_issue_i = 1'b0;
        ld_valid_i = 1'b1; ld_addr_i = 5'd9; ld_data_i = 32'h99;
        step;
        ld_valid_i = 1'b0; ld_issue_i = 1'b1; ld_issue_addr_i = 5'd9; settle;
        chk("hz9_pop_addr", rd_addr_o, 9);
        chk("hz9_pop_hazard", hazard_o, 1);
        step;
        ld_issue_i = 1'b0; settle;
        chk("hz9_kept", hazard_o, 1);
        step;
        chk("hz9_kept2", hazard_o, 1);

        // x0 writes: core x0 is idle, late x0 popped without write
        wb_valid_i = 1'b1; wb_addr_i = 5'd0; wb_data_i = 32'hF0;
        ld_valid_i = 1'b1; ld_addr_i = 5'd0; ld_data_i = 32'h5; settle;
        chk("x0_core_wren", rd_wren_o, 0);
        step;
        ld_valid_i = 1'b0; settle;
        chk("x0_late_wren", rd_wren_o, 0);
        chk("x0_late_data", rd_data_o, 32'h5);
        step;
        chk("x0_popped_data", rd_data_o, 0);
        chk("x0_popped_ready", ld_ready_o, 1);

        // mid-operation reset discards queued entries
        wb_addr_i = 5'd1; wb_data_i = 32'h11;
        ld_valid_i = 1'b1; ld_addr_i = 5'd4; ld_data_i = 32'h44;
        step;
        ld_addr_i = 5'd6; ld_data_i = 32'h66;
        step;
        ld_valid_i = 1'b0; settle;
        chk("mr_full", ld_ready_o, 0);
        rst_ni = 1'b0; settle;
        chk("mr_wren", rd_wren_o, 0);
        chk("mr_ready", ld_ready_o, 0);
        chk("mr_hazard", hazard_o, 0);
        step;
        rst_ni = 1'b1; wb_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step;
            chk($sformatf("mr_nowrite%0d", i), rd_wren_o, 0);
            chk($sformatf("mr_ready%0d", i), ld_ready_o, 1);
        end
        chk("mr_pend_cleared", hazard_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
